// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin push/pop arbiter in front of one LIFO instance.
// Owns the stack clear, tracks depth, and rejects overflow/underflow.
module stack_arbiter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [1:0]         req_op,
    input  logic [2*WIDTH-1:0] req_data,
    output logic [1:0]         req_ready,
    output logic [1:0]         rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    input  logic               flush,
    output logic               stk_push,
    output logic               stk_pop,
    output logic               stk_clear,
    output logic [WIDTH-1:0]   stk_wdata,
    input  logic [WIDTH-1:0]   stk_rdata,
    output logic [DW-1:0]      depth,
    output logic               full,
    output logic               empty,
    output logic [7:0]         err_count
);

    typedef enum logic [1:0] {
        S_INIT,
        S_CLEAR,
        S_RUN
    } state_t;

    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic             grant;
    logic             winner;
    logic             win_op;
    logic [WIDTH-1:0] win_data;
    logic             push_ok;
    logic             pop_ok;
    logic             rej;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the stack is cleared for exactly one cycle in CLEAR
    always_comb begin
        state_nxt = state;
        stk_clear = 1'b0;
        unique case (state)
            S_INIT: begin
                state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                stk_clear = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (flush) begin
                    state_nxt = S_CLEAR;
                end
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Pick the winner: a lone requester wins, otherwise rr_ptr decides
    always_comb begin
        grant  = (state == S_RUN) && !flush && (|req_valid);
        winner = 1'b0;
        unique case (req_valid)
            2'b11:   winner = rr_ptr;
            2'b10:   winner = 1'b1;
            default: winner = 1'b0;
        endcase
        win_op   = req_op[winner];
        win_data = winner ? req_data[2*WIDTH-1:WIDTH]
                          : req_data[WIDTH-1:0];
    end

    // Grant and stack strobes; a rejected op touches neither the stack nor depth
    always_comb begin
        req_ready = 2'b00;
        if (grant) begin
            req_ready = winner ? 2'b10 : 2'b01;
        end
        push_ok   = grant && !win_op && (depth != DEPTH_MAX);
        pop_ok    = grant && win_op && (depth != '0);
        rej       = grant && !push_ok && !pop_ok;
        stk_push  = push_ok;
        stk_pop   = pop_ok;
        stk_wdata = push_ok ? win_data : '0;
    end

    // Depth tracks the stack; CLEAR empties it alongside stk_clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            depth <= '0;
        end else if (state == S_CLEAR) begin
            depth <= '0;
        end else if (push_ok) begin
            depth <= depth + DW'(1);
        end else if (pop_ok) begin
            depth <= depth - DW'(1);
        end
    end

    // Round-robin pointer favours the loser of the last accept
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
        end else if (grant) begin
            rr_ptr <= ~winner;
        end
    end

    // Saturating count of rejected requests
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (rej && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    // One-cycle registered response; pop data is captured with the pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= req_ready;
            rsp_data  <= pop_ok ? stk_rdata : '0;
            rsp_err   <= rej;
        end
    end

    assign full  = (depth == DEPTH_MAX);
    assign empty = (depth == '0);

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: random and directed stimulus against a queue-based model.
// Responses are predicted into a scoreboard and checked by a monitor.
module tb_stack_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_op = '0;
    logic [7:0] req_data = '0;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic       flush = 1'b0;
    logic       stk_push;
    logic       stk_pop;
    logic       stk_clear;
    logic [3:0] stk_wdata;
    logic [3:0] stk_rdata;
    logic [4:0] depth;
    logic       full;
    logic       empty;
    logic [7:0] err_count;

    stack_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_clear (stk_clear),
        .stk_wdata (stk_wdata),
        .stk_rdata (stk_rdata),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    // Stand-in for the LIFO instance the arbiter drives
    logic [3:0] mem [16];
    int         sp = 0;

    assign stk_rdata = (sp > 0 && sp <= 16) ? mem[sp-1] : 4'h0;

    always @(posedge clock) begin
        if (stk_clear) begin
            sp <= 0;
        end else if (stk_push && sp < 16) begin
            mem[sp] <= stk_wdata;
            sp <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [1:0] port;
        logic [3:0] data;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] ref_stk[$];
    int         phase = 2;
    logic       pref = 1'b0;
    int         ecount = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", n, a, x, $time);
        end
    endtask

    // Monitor: a response is due exactly on the cycle recorded at accept
    exp_t mon_e;
    always @(negedge clock) begin
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.port));
            chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end else begin
            chk("rsp_idle", 32'(rsp_valid), 32'd0);
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        flush = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_data, rsp_err}), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        phase = 2;
        ref_stk.delete();
        pref = 1'b0;
        ecount = 0;
    endtask

    // One clock of stimulus; model predicts strobes and the response
    task automatic step(input logic [1:0] v, input logic [1:0] op,
                        input logic [7:0] d, input logic fl);
        logic [1:0] rdy;
        logic       push;
        logic       pop;
        logic [3:0] wd;
        logic [3:0] wv;
        logic       w;
        int         sz;
        exp_t       e;
        req_valid = v;
        req_op = op;
        req_data = d;
        flush = fl;
        #1;
        rdy = '0;
        push = 1'b0;
        pop = 1'b0;
        wd = '0;
        wv = '0;
        sz = ref_stk.size();
        e.due = cyc + 1;
        e.port = '0;
        e.data = '0;
        e.err = 1'b0;
        if (phase == 0 && !fl && v != 2'b00) begin
            w = (v == 2'b11) ? pref : v[1];
            rdy = w ? 2'b10 : 2'b01;
            pref = !w;
            e.port = rdy;
            wv = w ? d[7:4] : d[3:0];
            if (!op[w]) begin
                if (sz < 16) begin
                    push = 1'b1;
                    wd = wv;
                end else begin
                    e.err = 1'b1;
                end
            end else begin
                if (sz > 0) begin
                    pop = 1'b1;
                    e.data = ref_stk[sz-1];
                end else begin
                    e.err = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        chk("req_ready", 32'(req_ready), 32'(rdy));
        chk("stk_push", 32'(stk_push), 32'(push));
        chk("stk_pop", 32'(stk_pop), 32'(pop));
        chk("stk_wdata", 32'(stk_wdata), 32'(wd));
        chk("stk_clear", 32'(stk_clear), 32'(phase == 1));
        chk("depth", 32'(depth), 32'(sz));
        chk("full", 32'(full), 32'(sz == 16));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("err_count", 32'(err_count), 32'(ecount));
        if (push) ref_stk.push_back(wv);
        if (pop) void'(ref_stk.pop_back());
        if (e.err && ecount < 255) ecount++;
        if (phase == 1) ref_stk.delete();
        if (phase > 0) phase--;
        else if (fl) phase = 1;
        @(posedge clock);
        #1;
    endtask

    logic [7:0] pd;

    initial begin
        // Reset release, INIT, CLEAR, then push 3/7/A and pop them back
        do_reset();
        step(2'b01, 2'b00, 8'h03, 1'b0);
        step(2'b01, 2'b00, 8'h03, 1'b0);
        step(2'b01, 2'b00, 8'h03, 1'b0);
        step(2'b01, 2'b00, 8'h07, 1'b0);
        step(2'b01, 2'b00, 8'h0A, 1'b0);
        chk("t2_depth3", 32'(depth), 32'd3);
        repeat (3) step(2'b01, 2'b01, 8'h00, 1'b0);
        chk("t2_empty", 32'(empty), 32'd1);

        // Both ports pushing: grants alternate from port 0
        do_reset();
        repeat (2) step(2'b00, 2'b00, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 8'h5C, 1'b0);
        chk("t3_depth4", 32'(depth), 32'd4);

        // Overflow on the 17th push
        do_reset();
        repeat (2) step(2'b00, 2'b00, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) step(2'b01, 2'b00, 8'(i), 1'b0);
        chk("t4_depth16", 32'(depth), 32'd16);
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_errcnt", 32'(err_count), 32'd1);

        // Underflow: pop from empty on port 1
        do_reset();
        repeat (2) step(2'b00, 2'b00, 8'h00, 1'b0);
        step(2'b10, 2'b10, 8'h00, 1'b0);
        chk("t5_depth0", 32'(depth), 32'd0);

        // Flush with a pending request from port 1
        do_reset();
        repeat (2) step(2'b00, 2'b00, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b01, 2'b00, 8'(i + 1), 1'b0);
        step(2'b10, 2'b00, 8'h90, 1'b1);
        step(2'b10, 2'b00, 8'h90, 1'b0);
        step(2'b10, 2'b00, 8'h90, 1'b0);
        chk("t6_depth1", 32'(depth), 32'd1);

        // Random traffic with occasional flushes and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                pd = 8'($urandom);
                step(2'($urandom), 2'($urandom), pd,
                     $urandom_range(0, 24) == 0);
            end
        end
        repeat (3) step(2'b00, 2'b00, 8'h00, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
